// File: rtl/timer_set_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : timer_set_datapath                                            |
// | Brief    : Digit registers, 8-slot BCD set-memory and HH:MM:SS countdown  |
// |            driven by the timer-set PLA controller's control word.        |
// |            Optional load range check: TIMER_SET_RANGE_CHECK_EN            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module timer_set_datapath #(
    parameter int K_TERM        = 7,
    parameter int HOUR_TENS_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  T,
    input  logic [1:0]  s,
    input  logic        Kc,
    input  logic        La,
    input  logic        Lb,
    input  logic        Ea,
    input  logic        Lr,
    input  logic        Er,
    input  logic [3:0]  digit_in,
    input  logic        tick_1hz,
    output logic        k7,
    output logic [2:0]  k_q,
    output logic [3:0]  a_q,
    output logic [3:0]  b_q,
    output logic [7:0]  r_hh,
    output logic [7:0]  r_mm,
    output logic [7:0]  r_ss,
    output logic        running,
    output logic        done,
    output logic        err
);

    localparam logic [2:0]  c_K_TERM  = 3'(K_TERM);
    localparam logic [3:0]  c_HTM     = 4'(HOUR_TENS_MAX);
    // Per-digit wrap value on borrow, least significant digit in bits [3:0]
    localparam logic [23:0] c_DIG_MAX = 24'h995959;

    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic [2:0]  r_k;
    logic [3:0]  r_slot [8];
    logic [23:0] r_r;
    logic        r_done;

    logic [3:0]  w_din_clamp;
    logic [3:0]  w_a_next;
    logic [3:0]  w_slot_eff [6];
    logic [23:0] w_load;
    logic [23:0] w_r_dec;
    logic        w_r_zero;
    logic        w_range_ok;
    logic        w_load_ok;
    logic        w_count;

    function automatic logic [23:0] bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = c_DIG_MAX[i*4 +: 4];
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_din_clamp = (digit_in > 4'd9) ? 4'd9 : digit_in;

    always_comb begin
        w_a_next = 4'd0;
        case (s)
            2'd0:    w_a_next = w_din_clamp;
            2'd1:    w_a_next = (r_a >= 4'd9) ? 4'd0 : r_a + 4'd1;
            2'd2:    w_a_next = r_b;
            default: w_a_next = 4'd0;
        endcase
    end

    // Write-through so an Ea into slots 0-5 in the same cycle reaches R
    for (genvar g = 0; g < 6; g++) begin : g_slot_eff
        assign w_slot_eff[g] = (Ea && (r_k == 3'(g))) ? r_a : r_slot[g];
    end

    assign w_load = {w_slot_eff[0], w_slot_eff[1], w_slot_eff[2],
                     w_slot_eff[3], w_slot_eff[4], w_slot_eff[5]};

    assign w_range_ok = !(w_load[23:20] > c_HTM) && !(w_load[23:16] > 8'h23) &&
                        !(w_load[15:12] > 4'd5)  && !(w_load[7:4] > 4'd5);

`ifdef TIMER_SET_RANGE_CHECK_EN
    logic r_err;
    logic w_unused;
    assign w_load_ok = w_range_ok;
    assign w_unused  = ^T;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (Lr) begin
            r_err <= !w_range_ok;
        end
    end
`else
    logic w_unused;
    assign w_load_ok = 1'b1;
    assign w_unused  = ^{T, w_range_ok};
    assign err       = 1'b0;
`endif

    assign w_r_zero = (r_r == 24'd0);
    assign w_r_dec  = bcd_dec(r_r);
    assign w_count  = Er && tick_1hz && !w_r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= 4'd0;
            r_b    <= 4'd0;
            r_k    <= 3'd0;
            r_r    <= 24'd0;
            r_done <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_slot[i] <= 4'd0;
            end
        end else begin
            if (La) r_a <= w_a_next;
            if (Lb) r_b <= w_din_clamp;
            if (Ea) r_slot[r_k] <= r_a;
            if (Kc) begin
                r_k <= 3'd0;
            end else if (Ea) begin
                r_k <= r_k + 3'd1;
            end
            if (Lr) begin
                if (w_load_ok) begin
                    r_r    <= w_load;
                    r_done <= 1'b0;
                end
            end else if (w_count) begin
                r_r <= w_r_dec;
                if (w_r_dec == 24'd0) r_done <= 1'b1;
            end
        end
    end

    assign k7      = (r_k == c_K_TERM);
    assign k_q     = r_k;
    assign a_q     = r_a;
    assign b_q     = r_b;
    assign r_hh    = r_r[23:16];
    assign r_mm    = r_r[15:8];
    assign r_ss    = r_r[7:0];
    assign running = Er && !w_r_zero;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_timer_set_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_timer_set_datapath                                         |
// | Brief    : Scoreboard bench for timer_set_datapath                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_timer_set_datapath;

    localparam int S_K = 0, S_A = 1, S_B = 2, S_R = 3, S_RUN = 4, S_DONE = 5, S_ERR = 6, S_K7 = 7;

    typedef struct {
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, Kc, La, Lb, Ea, Lr, Er, tick_1hz;
    logic [3:0] T, digit_in;
    logic [1:0] s;
    logic       k7, running, done, err;
    logic [2:0] k_q;
    logic [3:0] a_q, b_q;
    logic [7:0] r_hh, r_mm, r_ss;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    timer_set_datapath dut (
        .clk(clk), .rst(rst), .T(T), .s(s), .Kc(Kc), .La(La), .Lb(Lb), .Ea(Ea),
        .Lr(Lr), .Er(Er), .digit_in(digit_in), .tick_1hz(tick_1hz), .k7(k7),
        .k_q(k_q), .a_q(a_q), .b_q(b_q), .r_hh(r_hh), .r_mm(r_mm), .r_ss(r_ss),
        .running(running), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic string sel_name(input int sel);
        case (sel)
            S_K:     return "k_q";
            S_A:     return "a_q";
            S_B:     return "b_q";
            S_R:     return "R";
            S_RUN:   return "running";
            S_DONE:  return "done";
            S_ERR:   return "err";
            default: return "k7";
        endcase
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_K:     return 32'(k_q);
            S_A:     return 32'(a_q);
            S_B:     return 32'(b_q);
            S_R:     return {8'd0, r_hh, r_mm, r_ss};
            S_RUN:   return 32'(running);
            S_DONE:  return 32'(done);
            S_ERR:   return 32'(err);
            default: return 32'(k7);
        endcase
    endfunction

    task automatic expect_val(input int sel, input logic [31:0] val);
        exp_t e;
        e.sel = sel;
        e.val = val;
        q.push_back(e);
    endtask

    // Advance one clock, then compare everything queued for this edge
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            check(sel_name(e.sel), observe(e.sel), e.val);
        end
        {rst, Kc, La, Lb, Ea, Lr, Er, tick_1hz} = '0;
        s = 2'd0;
    endtask

    // Slot i gets digit v[23-4i -: 4]; leaves K = 6
    task automatic write_slots(input logic [23:0] v);
        Kc = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            La = 1'b1; s = 2'd0; digit_in = v[23-4*i -: 4];
            step();
            Ea = 1'b1;
            if (i == 5) expect_val(S_K, 6);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] digits;
        T = 4'd0; s = 2'd3; digit_in = 4'd7;
        // Reset with every control asserted
        {rst, Kc, La, Lb, Ea, Lr, Er, tick_1hz} = '1;
        @(posedge clk); #1;
        rst = 1'b1; Kc = 1'b1; La = 1'b1; Lb = 1'b1; Ea = 1'b1; Lr = 1'b1; Er = 1'b1; tick_1hz = 1'b1;
        for (int i = 0; i < 8; i++) expect_val(i, 0);
        step();

        // Digit entry 0,1,3,0,0,5
        digits = 24'h013005;
        for (int i = 0; i < 6; i++) begin
            La = 1'b1; s = 2'd0; digit_in = digits[23-4*i -: 4];
            expect_val(S_A, 32'(digits[23-4*i -: 4]));
            step();
            Ea = 1'b1;
            expect_val(S_K, i + 1);
            expect_val(S_K7, 0);
            step();
        end
        Ea = 1'b1; expect_val(S_K, 7); expect_val(S_K7, 1); step();
        Ea = 1'b1; expect_val(S_K, 0); expect_val(S_K7, 0); step();
        Lr = 1'b1; expect_val(S_R, 32'h013005); step();

        // Source mux and clamp
        La = 1'b1; s = 2'd0; digit_in = 4'd12; expect_val(S_A, 9); step();
        La = 1'b1; s = 2'd1; expect_val(S_A, 0); step();
        La = 1'b1; s = 2'd1; expect_val(S_A, 1); step();
        Lb = 1'b1; digit_in = 4'd4; expect_val(S_B, 4); expect_val(S_A, 1); step();
        La = 1'b1; s = 2'd2; expect_val(S_A, 4); step();
        La = 1'b1; s = 2'd3; expect_val(S_A, 0); step();
        La = 1'b1; s = 2'd2; Lb = 1'b1; digit_in = 4'd13;
        expect_val(S_A, 4); expect_val(S_B, 9); step();

        // Countdown borrow
        write_slots(24'h010000);
        Lr = 1'b1; expect_val(S_R, 32'h010000); expect_val(S_DONE, 0); step();
        Er = 1'b1; expect_val(S_R, 32'h010000); expect_val(S_RUN, 1); step();
        Er = 1'b1; tick_1hz = 1'b1; expect_val(S_R, 32'h005959); step();
        write_slots(24'h100000);
        Lr = 1'b1; step();
        Er = 1'b1; tick_1hz = 1'b1; expect_val(S_R, 32'h095959); step();
        write_slots(24'h000002);
        Lr = 1'b1; step();
        Er = 1'b1; tick_1hz = 1'b1; expect_val(S_R, 32'h000001); expect_val(S_DONE, 0); step();
        Er = 1'b1; tick_1hz = 1'b1; expect_val(S_R, 32'h000000);
        expect_val(S_DONE, 1); expect_val(S_RUN, 0); step();
        Er = 1'b1; tick_1hz = 1'b1; expect_val(S_R, 32'h000000); expect_val(S_DONE, 1); step();

        // Simultaneous events
        Kc = 1'b1; step();
        digits = 24'h001230;
        for (int i = 0; i < 5; i++) begin
            La = 1'b1; digit_in = digits[23-4*i -: 4]; step();
            Ea = 1'b1; step();
        end
        La = 1'b1; digit_in = 4'd7; step();
        Ea = 1'b1; Lr = 1'b1;
        expect_val(S_R, 32'h001237); expect_val(S_K, 6); expect_val(S_DONE, 0); step();
        Lr = 1'b1; Er = 1'b1; tick_1hz = 1'b1; expect_val(S_R, 32'h001237); step();
        Kc = 1'b1; step();
        La = 1'b1; digit_in = 4'd1; step();
        Ea = 1'b1; expect_val(S_K, 1); step();
        La = 1'b1; digit_in = 4'd2; step();
        Kc = 1'b1; Ea = 1'b1; expect_val(S_K, 0); step();
        Lr = 1'b1; expect_val(S_R, 32'h121237); step();

        // Range check on load
        write_slots(24'h246100);
        Lr = 1'b1;
`ifdef TIMER_SET_RANGE_CHECK_EN
        expect_val(S_R, 32'h121237); expect_val(S_ERR, 1);
`else
        expect_val(S_R, 32'h246100); expect_val(S_ERR, 0);
`endif
        step();
        write_slots(24'h235959);
        Lr = 1'b1; expect_val(S_R, 32'h235959); expect_val(S_ERR, 0); step();

        // Reset in the middle of a countdown
        Er = 1'b1; tick_1hz = 1'b1; expect_val(S_R, 32'h235958); expect_val(S_RUN, 1); step();
        rst = 1'b1; Er = 1'b1; step();
        Er = 1'b1;
        expect_val(S_R, 0); expect_val(S_DONE, 0); expect_val(S_RUN, 0); expect_val(S_K, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer_set_datapath.md
Name: timer_set_datapath

Overview:
Datapath stage controlled by the timer-set PLA controller. It consumes the controller's registered control word (T, s, Kc, La, Lb, Ea, Lr, Er) and returns the status flag k7 that drives the controller's state-7 branch. It holds:
- the digit working registers A and B;
- an 8-slot BCD set-memory indexed by step counter K;
- a BCD HH:MM:SS countdown register R that runs on a 1 Hz tick.

Parameters:
K_TERM, 7, K value at which k7 asserts.
HOUR_TENS_MAX, 2, largest hours-tens digit accepted by the range check.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
T  in  4  controller state code; debug only, no functional effect.
s  in  2  A-load source select.
Kc  in  1  clear step counter K.
La  in  1  load A.
Lb  in  1  load B.
Ea  in  1  write A into slot K, then increment K.
Lr  in  1  load R from set-memory.
Er  in  1  countdown enable.
digit_in  in  4  digit from set buttons.
tick_1hz  in  1  one-cycle pulse, 1 Hz.
k7  out  1  (k_q == K_TERM).
k_q  out  3  step counter.
a_q  out  4  register A.
b_q  out  4  register B.
r_hh  out  8  countdown hours, BCD.
r_mm  out  8  countdown minutes, BCD.
r_ss  out  8  countdown seconds, BCD.
running  out  1  Er && (R != 0).
done  out  1  sticky countdown-complete flag.
err  out  1  load-rejected flag (optional feature).

Behaviour:
- Reset: clock is clk; reset rst is synchronous and active-high. Reset clears A, B, K, all 8 slots, R, done and err to 0. k7 = 0 after reset (with K_TERM != 0).
- A-source mux (used when La = 1):
  - s = 0: digit_in, clamped to 9 if > 9.
  - s = 1: (A + 1) mod 10.
  - s = 2: B (old value).
  - s = 3: 0.
- Lb: B <= clamped digit_in.
- La and Lb are independent. Same cycle with s = 2: A takes old B.
- Ea: slot[K] <= A (old A). Then K <= K + 1, wrapping 7 -> 0.
- Kc clears K. Kc + Ea in the same cycle: write goes to old K, then K = 0 (Kc wins over increment).
- k7: combinational decode of the k_q register. Valid the cycle after the K update, before the controller's next sample.
- Lr loads R: r_hh = {slot0, slot1}, r_mm = {slot2, slot3}, r_ss = {slot4, slot5}.
  - Slots 6–7 are stored but not used.
  - Lr uses write-through: if Ea writes slot 0–5 in the same cycle, R receives the new A.
  - Lr clears done.
  - Lr has priority over Er.
- Countdown: on Er && tick_1hz && R != 0, decrement R by one second with BCD borrow.
  - Borrow chain: ss units 0 -> 9 with borrow; ss tens 0 -> 5 with borrow; mm the same; hh units 0 -> 9 with borrow from hh tens.
  - Latency: one clock after the tick.
  - When R becomes 000000, done <= 1 in the same edge.
  - R == 0 with Er: R holds, no underflow. done holds until the next Lr or rst.
  - Er low or no tick: R holds.
- rst mid-countdown: R = 0, done = 0, running = 0 next cycle.

Optional Feature:
TIMER_SET_RANGE_CHECK_EN
- Defined: Lr rejects the load if any of the following hold:
  - hh tens > HOUR_TENS_MAX;
  - hh > 23;
  - mm tens > 5;
  - ss tens > 5.
  On rejection, R and done are unchanged and err <= 1. An accepted Lr clears err. err is sticky otherwise.
- Undefined: Lr loads unconditionally and err is tied to 0.

Test Plan:
- Reset: rst high for 2 cycles with all controls active -> every output 0, k7 = 0.
- Digit entry: write slots 0..5 = 0,1,3,0,0,5 via La (s=0) then Ea per slot (Ea asserted 6 times) -> k_q = 6, k7 = 0. Two more Ea -> k_q = 0 (wrap); k7 high only while k_q = 7.
- Mux and clamp: digit_in = 12 with La, s=0 -> a_q = 9. La, s=1 -> a_q = 0. Lb with digit_in = 4, then La, s=2 -> a_q = 4. La, s=3 -> a_q = 0.
- Countdown borrow: load R = 01:00:00 via Lr. Assert Er with one tick -> 00:59:59. From 00:00:02, three ticks -> 00:00:01, 00:00:00 (done = 1, running = 0), then held.
- Simultaneous events: Lr with Ea writing slot 5 = 7 -> r_ss units = 7. Lr, Er and tick in the same cycle -> R = the loaded value, no decrement. Kc + Ea -> slot[old K] written, k_q = 0.
- With TIMER_SET_RANGE_CHECK_EN: slots giving 24:61:00 then Lr -> R unchanged, err = 1. A valid Lr afterwards -> err = 0. Without the macro: R = 24:61:00 and err = 0.
